// File: rtl/plazer_st_arb_pkg.sv
// Shared types and helpers for the packet-aware Avalon-ST round-robin arbiter.
package plazer_st_arb_pkg;

  // Arbiter FSM: IDLE picks the next source, LOCKED forwards one packet.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of the delivered-packet counter.
  localparam int PKT_CNT_W = 16;

  // Widest channel encoding idx2ch can produce; callers truncate to CH_W.
  localparam int CH_MAX_W = 32;

  // Zero-extend a source index into a channel number.
  function automatic logic [CH_MAX_W-1:0] idx2ch(input logic [CH_MAX_W-1:0] idx);
    idx2ch = idx;
  endfunction

endpackage

// File: rtl/plazer_rr_picker.sv
// Combinational round-robin search: first requester after `last_i`, with wrap.
module plazer_rr_picker
  import plazer_st_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  last_i,
  output logic [IDX_W-1:0]  pick_o,
  output logic              any_o
);

  int               cand_s;
  logic [IDX_W-1:0] idx_s;

  // Walk last+1, last+2, ... last+NUM_IN (last itself comes last) and keep the first hit.
  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    cand_s = 0;
    idx_s  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand_s = (int'(last_i) + k) % NUM_IN;
      idx_s  = cand_s[IDX_W-1:0];
      if (!any_o && req_i[idx_s]) begin
        pick_o = idx_s;
        any_o  = 1'b1;
      end else begin
        pick_o = pick_o;
        any_o  = any_o;
      end
    end
  end

endmodule

// File: rtl/plazer_master_0_st_pkt_arbiter.sv
// Packet-aware round-robin arbiter sharing one channelized Avalon-ST path
// between NUM_IN packet sources. The grant is locked from the first accepted
// beat to EOP; every output beat carries the granted source on out_channel.
// Optional build macro PLAZER_ARB_PKT_COUNT_EN enables the delivered-EOP
// counter on out_pkt_count; without it that port is tied to zero.
module plazer_master_0_st_pkt_arbiter
  import plazer_st_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CH_W-1:0]          out_channel,
  output logic [PKT_CNT_W-1:0]     out_pkt_count
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  arb_state_e        state_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic [IDX_W-1:0]  pick_s;
  logic              any_s;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sop_q;
  logic              out_eop_q;
  logic [CH_W-1:0]   out_channel_q;

  logic              sel_valid_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_sop_s;
  logic              sel_eop_s;
  logic              accept_s;
  logic              transfer_s;
  logic [NUM_IN-1:0] in_ready_s;

  plazer_rr_picker #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req_i  (in_valid),
    .last_i (last_grant_q),
    .pick_o (pick_s),
    .any_o  (any_s)
  );

  // Select the granted source's beat and decide whether it moves this cycle.
  always_comb begin
    sel_valid_s = in_valid[grant_q];
    sel_data_s  = in_data[grant_q*DATA_W +: DATA_W];
    sel_sop_s   = in_startofpacket[grant_q];
    sel_eop_s   = in_endofpacket[grant_q];
    // Output register can take a beat if empty or draining this cycle.
    accept_s    = !out_valid_q || out_ready;
    in_ready_s  = '0;
    if (state_q == ARB_LOCKED) begin
      in_ready_s[grant_q] = accept_s;
    end else begin
      in_ready_s = '0;
    end
    transfer_s = (state_q == ARB_LOCKED) && sel_valid_s && accept_s;
  end

  // Arbitration FSM plus the registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_IN - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_channel_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // The IDLE cycle is the deliberate bubble between packets.
          if (any_s) begin
            grant_q <= pick_s;
            state_q <= ARB_LOCKED;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          // Only EOP releases the grant; a stalled or mid-packet SOP source keeps it.
          if (transfer_s && sel_eop_s) begin
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end else begin
            state_q <= ARB_LOCKED;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase

      if (transfer_s) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= sel_data_s;
        out_sop_q     <= sel_sop_s;
        out_eop_q     <= sel_eop_s;
        out_channel_q <= CH_W'(idx2ch(CH_MAX_W'(grant_q)));
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end
    end
  end

  assign in_ready          = in_ready_s;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_channel       = out_channel_q;

`ifdef PLAZER_ARB_PKT_COUNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  // Count EOP beats accepted downstream; wraps naturally at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_eop_q) begin
      pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
    end else begin
      pkt_cnt_q <= pkt_cnt_q;
    end
  end

  assign out_pkt_count = pkt_cnt_q;
`else
  assign out_pkt_count = '0;
`endif

endmodule
